// File: rtl/vault_pkg.sv
// vault_pkg: shared definitions for the vault work scheduler.
//   - header width and nonce-field bit positions
//   - result status encodings and scheduler FSM state type
//   - saturating increment helper used by the hashrate meter
package vault_pkg;

  localparam int unsigned HDR_W     = 640;
  localparam int unsigned NONCE_MSB = 639;
  localparam int unsigned NONCE_LSB = 608;

  typedef enum logic [1:0] {
    RES_FOUND     = 2'd0,
    RES_EXHAUSTED = 2'd1,
    RES_TIMEOUT   = 2'd2,
    RES_ABORTED   = 2'd3
  } res_status_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_RUN      = 2'd2,
    ST_REPORT   = 2'd3
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] a, input logic inc);
    logic [32:0] s;
    s = {1'b0, a} + {32'd0, inc};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/vault_hashrate_meter.sv
// vault_hashrate_meter: counts hash_tick pulses over a fixed window of
// WINDOW_CYC cycles and publishes the saturated count of the last complete
// window.
//   clk       in   clock
//   rst       in   asynchronous active-high reset
//   hash_tick in   one pulse per evaluated hash
//   hashrate  out  hashes counted in the last complete window
module vault_hashrate_meter
  import vault_pkg::*;
#(
  parameter int unsigned WINDOW_CYC = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hash_tick,
  output logic [31:0] hashrate
);

  logic [31:0] win_cnt;
  logic [31:0] hash_cnt;
  logic [31:0] hash_sum;

  assign hash_sum = sat_inc(hash_cnt, hash_tick);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt  <= '0;
      hash_cnt <= '0;
      hashrate <= '0;
    end else if (win_cnt >= WINDOW_CYC - 1) begin
      // last window cycle: its own tick is included in the published value
      win_cnt  <= '0;
      hash_cnt <= '0;
      hashrate <= hash_sum;
    end else begin
      win_cnt  <= win_cnt + 32'd1;
      hash_cnt <= hash_sum;
    end
  end

endmodule

// File: rtl/vault_work_scheduler.sv
// vault_work_scheduler: accepts one mining job at a time, dispatches it to a
// mining core in NONCE_STEP-sized nonce ranges, and reports the outcome
// (found / exhausted / timeout / aborted). Also measures core hashrate.
//   clk, rst                      clock, asynchronous active-high reset
//   job_valid/job_ready           job offer handshake
//   job_data[640], job_id[8]      header (nonce in [639:608]) and tag
//   abort                         drop the current job
//   core_start, core_work[640]    dispatch pulse and header with range base
//   core_done/found/nonce[32]     core range completion report
//   hash_tick                     one pulse per hash from the core
//   res_valid/res_ready           result handshake
//   res_id[8], res_nonce[32], res_status[2]   result fields
//   busy                          scheduler not idle
//   hashrate[32]                  hashes in the last complete window
module vault_work_scheduler
  import vault_pkg::*;
#(
  parameter logic [31:0] NONCE_STEP  = 32'h0100_0000,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned WINDOW_CYC  = 100_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [HDR_W-1:0]   job_data,
  input  logic [7:0]         job_id,
  input  logic               abort,
  output logic               core_start,
  output logic [HDR_W-1:0]   core_work,
  input  logic               core_done,
  input  logic               core_found,
  input  logic [31:0]        core_nonce,
  input  logic               hash_tick,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [7:0]         res_id,
  output logic [31:0]        res_nonce,
  output logic [1:0]         res_status,
  output logic               busy,
  output logic [31:0]        hashrate
);

  state_t      state;
  logic [31:0] base;
  logic [31:0] tmo_cnt;
  logic [32:0] next_base;
  logic        timeout_hit;

  assign next_base   = {1'b0, base} + {1'b0, NONCE_STEP};
  assign timeout_hit = (tmo_cnt >= TIMEOUT_CYC - 1);

  assign job_ready  = (state == ST_IDLE);
  assign core_start = (state == ST_DISPATCH);
  assign res_valid  = (state == ST_REPORT);
  assign busy       = (state != ST_IDLE);

  // The timeout counter is zeroed on entry to DISPATCH and counts the
  // DISPATCH cycle too, so a dispatch spans at most TIMEOUT_CYC cycles
  // starting with the core_start cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      base       <= '0;
      tmo_cnt    <= '0;
      core_work  <= '0;
      res_id     <= '0;
      res_nonce  <= '0;
      res_status <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (job_valid) begin
            base      <= job_data[NONCE_MSB:NONCE_LSB];
            core_work <= job_data;
            res_id    <= job_id;
            tmo_cnt   <= '0;
            state     <= ST_DISPATCH;
          end
        end

        ST_DISPATCH: begin
          tmo_cnt <= tmo_cnt + 32'd1;
          if (abort) begin
            res_status <= RES_ABORTED;
            res_nonce  <= base;
            state      <= ST_REPORT;
          end else begin
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          tmo_cnt <= tmo_cnt + 32'd1;
          if (abort) begin
            res_status <= RES_ABORTED;
            res_nonce  <= base;
            state      <= ST_REPORT;
          end else if (core_done) begin
            if (core_found) begin
              res_status <= RES_FOUND;
              res_nonce  <= core_nonce;
              state      <= ST_REPORT;
            end else if (next_base[32]) begin
              res_status <= RES_EXHAUSTED;
              res_nonce  <= '1;
              state      <= ST_REPORT;
            end else begin
              base                           <= next_base[31:0];
              core_work[NONCE_MSB:NONCE_LSB] <= next_base[31:0];
              tmo_cnt                        <= '0;
              state                          <= ST_DISPATCH;
            end
          end else if (timeout_hit) begin
            res_status <= RES_TIMEOUT;
            res_nonce  <= base;
            state      <= ST_REPORT;
          end
        end

        ST_REPORT: begin
          if (res_ready) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  vault_hashrate_meter #(
    .WINDOW_CYC(WINDOW_CYC)
  ) u_meter (
    .clk      (clk),
    .rst      (rst),
    .hash_tick(hash_tick),
    .hashrate (hashrate)
  );

endmodule

// File: tb/tb_vault_work_scheduler.sv
// tb_vault_work_scheduler: table-driven job scenarios plus hand-written
// sequences for reset, hashrate window and mid-run reset.
module tb_vault_work_scheduler;

  localparam logic [31:0] STEP = 32'h0100_0000;

  typedef enum int {K_FOUND, K_EXHAUST, K_TIMEOUT, K_ABORT} kind_t;

  typedef struct {
    logic [31:0] nonce;
    logic [7:0]  id;
    kind_t       kind;
    int unsigned n_miss;
    int unsigned delay;
    logic [31:0] core_n;
    int unsigned hold;
    logic [1:0]  exp_status;
    logic [31:0] exp_nonce;
    int unsigned exp_starts;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         job_valid;
  logic         job_ready;
  logic [639:0] job_data;
  logic [7:0]   job_id;
  logic         abort;
  logic         core_start;
  logic [639:0] core_work;
  logic         core_done;
  logic         core_found;
  logic [31:0]  core_nonce;
  logic         hash_tick;
  logic         res_valid;
  logic         res_ready;
  logic [7:0]   res_id;
  logic [31:0]  res_nonce;
  logic [1:0]   res_status;
  logic         busy;
  logic [31:0]  hashrate;

  int unsigned checks;
  int unsigned errors;
  vec_t        vecs[7];

  vault_work_scheduler #(
    .NONCE_STEP (STEP),
    .TIMEOUT_CYC(16),
    .WINDOW_CYC (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .job_valid (job_valid),
    .job_ready (job_ready),
    .job_data  (job_data),
    .job_id    (job_id),
    .abort     (abort),
    .core_start(core_start),
    .core_work (core_work),
    .core_done (core_done),
    .core_found(core_found),
    .core_nonce(core_nonce),
    .hash_tick (hash_tick),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_nonce (res_nonce),
    .res_status(res_status),
    .busy      (busy),
    .hashrate  (hashrate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [607:0] pat(input logic [7:0] id);
    return {19{id, 24'hC0FFEE}};
  endfunction

  task automatic run_job(input vec_t v);
    int unsigned cyc;
    int unsigned start_cyc;
    int unsigned starts;
    int unsigned ranges;
    int unsigned timer;
    logic        armed;
    logic        prev_done;
    logic [7:0]  cap_id;
    logic [31:0] cap_nonce;
    logic [1:0]  cap_status;
    logic [31:0] exp_base;

    // abort while idle must not start anything
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_busy", {63'd0, busy}, 64'd0);
    check("idle_job_ready", {63'd0, job_ready}, 64'd1);

    job_valid = 1'b1;
    job_data  = {v.nonce, pat(v.id)};
    job_id    = v.id;

    cyc = 0; start_cyc = 0; starts = 0; ranges = 0; timer = 0;
    armed = 1'b0; prev_done = 1'b0;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      job_valid  = 1'b0;
      core_done  = 1'b0;
      core_found = 1'b0;
      abort      = 1'b0;
      if (cyc == 1) begin
        check("accept_to_start", {63'd0, core_start}, 64'd1);
        check("job_ready_busy", {63'd0, job_ready}, 64'd0);
      end
      if (prev_done) begin
        check("done_to_response", {63'd0, (core_start | res_valid)}, 64'd1);
        prev_done = 1'b0;
      end
      if (res_valid) break;
      if (core_start) begin
        exp_base = v.nonce + STEP * starts;
        check("core_work_base", {32'd0, core_work[639:608]}, {32'd0, exp_base});
        check("core_work_hdr", {32'd0, core_work[31:0]}, {32'd0, v.id, 24'hC0FFEE});
        check("core_work_hdr_full", {63'd0, (core_work[607:0] == pat(v.id))}, 64'd1);
        starts++;
        start_cyc = cyc;
        armed     = (v.kind != K_TIMEOUT);
        timer     = v.delay;
      end else if (armed) begin
        if (timer == 0) begin
          core_done  = 1'b1;
          core_found = ((v.kind == K_FOUND) || (v.kind == K_ABORT)) && (ranges == v.n_miss);
          core_nonce = v.core_n;
          abort      = (v.kind == K_ABORT) && (ranges == v.n_miss);
          ranges++;
          armed      = 1'b0;
          prev_done  = 1'b1;
        end else begin
          timer--;
        end
      end
    end

    check("res_valid_reached", {63'd0, res_valid}, 64'd1);
    check("res_status", {62'd0, res_status}, {62'd0, v.exp_status});
    check("res_nonce", {32'd0, res_nonce}, {32'd0, v.exp_nonce});
    check("res_id", {56'd0, res_id}, {56'd0, v.id});
    check("dispatch_count", 64'(starts), 64'(v.exp_starts));
    if (v.kind == K_TIMEOUT)
      check("timeout_latency", 64'(cyc - start_cyc), 64'd16);

    // hold off the result: fields stay put, late core_done and abort ignored
    cap_id = res_id; cap_nonce = res_nonce; cap_status = res_status;
    for (int unsigned h = 0; h < v.hold; h++) begin
      abort     = 1'b1;
      core_done = 1'b1;
      @(negedge clk);
      check("hold_valid", {63'd0, res_valid}, 64'd1);
      check("hold_job_ready", {63'd0, job_ready}, 64'd0);
      check("hold_fields", {22'd0, res_id, res_nonce, res_status},
            {22'd0, cap_id, cap_nonce, cap_status});
    end
    abort     = 1'b0;
    core_done = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("release_valid", {63'd0, res_valid}, 64'd0);
    check("release_busy", {63'd0, busy}, 64'd0);
    check("release_job_ready", {63'd0, job_ready}, 64'd1);
    check("hashrate_steady", {32'd0, hashrate}, 64'd10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic quiet;
    checks = 0;
    errors = 0;

    vecs[0] = '{32'h0000_0000, 8'hA5, K_FOUND,   1, 3, 32'h1234_5678, 2, 2'd0, 32'h1234_5678, 2};
    vecs[1] = '{32'hFF00_0000, 8'h3C, K_EXHAUST, 0, 2, 32'h0,         1, 2'd1, 32'hFFFF_FFFF, 1};
    vecs[2] = '{32'h4200_0000, 8'h07, K_TIMEOUT, 0, 0, 32'h0,         0, 2'd2, 32'h4200_0000, 1};
    vecs[3] = '{32'h1000_0000, 8'h99, K_ABORT,   0, 4, 32'hDEAD_0000, 5, 2'd3, 32'h1000_0000, 1};
    vecs[4] = '{32'h7F00_0000, 8'h11, K_FOUND,   0, 0, 32'h7F00_0042, 1, 2'd0, 32'h7F00_0042, 1};
    vecs[5] = '{32'hFD00_0000, 8'hE2, K_EXHAUST, 0, 1, 32'h0,         0, 2'd1, 32'hFFFF_FFFF, 3};
    vecs[6] = '{32'h2000_0000, 8'h5A, K_ABORT,   1, 2, 32'h0,         3, 2'd3, 32'h2100_0000, 2};

    rst        = 1'b1;
    job_valid  = 1'b0;
    job_data   = '0;
    job_id     = '0;
    abort      = 1'b0;
    core_done  = 1'b0;
    core_found = 1'b0;
    core_nonce = '0;
    hash_tick  = 1'b1;
    res_ready  = 1'b0;

    #3;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_core_start", {63'd0, core_start}, 64'd0);
    check("rst_res_valid", {63'd0, res_valid}, 64'd0);
    check("rst_res_fields", {22'd0, res_id, res_nonce, res_status}, 64'd0);
    check("rst_core_work_zero", {63'd0, (core_work == '0)}, 64'd1);
    check("rst_hashrate", {32'd0, hashrate}, 64'd0);

    // first window: hashrate published on the 10th edge after release
    @(negedge clk);
    rst = 1'b0;
    repeat (9) @(negedge clk);
    check("hashrate_before_window", {32'd0, hashrate}, 64'd0);
    @(negedge clk);
    check("hashrate_first_window", {32'd0, hashrate}, 64'd10);

    for (int unsigned i = 0; i < 7; i++) run_job(vecs[i]);

    // reset in the middle of RUN drops the job silently
    @(negedge clk);
    job_valid = 1'b1;
    job_data  = {32'h3000_0000, pat(8'h77)};
    job_id    = 8'h77;
    @(negedge clk);
    job_valid = 1'b0;
    check("mid_rst_start", {63'd0, core_start}, 64'd1);
    repeat (3) @(negedge clk);
    check("mid_rst_busy_before", {63'd0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_core_start", {63'd0, core_start}, 64'd0);
    check("mid_rst_res_valid", {63'd0, res_valid}, 64'd0);
    check("mid_rst_res_fields", {22'd0, res_id, res_nonce, res_status}, 64'd0);
    check("mid_rst_core_work_zero", {63'd0, (core_work == '0)}, 64'd1);
    check("mid_rst_hashrate", {32'd0, hashrate}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int unsigned k = 0; k < 10; k++) begin
      @(negedge clk);
      if (res_valid || core_start || busy) quiet = 1'b0;
    end
    check("mid_rst_no_result", {63'd0, quiet}, 64'd1);

    run_job(vecs[4]);
    run_job(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
